// File: rtl/avr_core_pkg.sv
// Shared definitions for the AVR core front end: sequencer state codes,
// two-word opcode mask/match pairs, the NOP encoding and the default PC width.
package avr_core_pkg;

    localparam int SEQ_PC_WIDTH = 14;

    localparam logic [2:0] SEQ_FETCH     = 3'd0;
    localparam logic [2:0] SEQ_WAIT      = 3'd1;
    localparam logic [2:0] SEQ_FETCH_EXT = 3'd2;
    localparam logic [2:0] SEQ_WAIT_EXT  = 3'd3;
    localparam logic [2:0] SEQ_EXECUTE   = 3'd4;
    localparam logic [2:0] SEQ_HALTED    = 3'd5;

    localparam logic [15:0] OPC_NOP = 16'h0000;

    // LDS/STS: 1001 00xd dddd 0000
    localparam logic [15:0] OPC_LDS_STS_MASK   = 16'hFC0F;
    localparam logic [15:0] OPC_LDS_STS_MATCH  = 16'h9000;
    // JMP/CALL: 1001 010k kkkk 11xk
    localparam logic [15:0] OPC_JMP_CALL_MASK  = 16'hFE0C;
    localparam logic [15:0] OPC_JMP_CALL_MATCH = 16'h940C;

    // True when the word is the first half of a two-word instruction
    function automatic logic is_two_word(input logic [15:0] word);
        return ((word & OPC_LDS_STS_MASK) == OPC_LDS_STS_MATCH) ||
               ((word & OPC_JMP_CALL_MASK) == OPC_JMP_CALL_MATCH);
    endfunction

endpackage

// File: rtl/two_word_detect.sv
// Combinational classifier: flags the first word of LDS/STS/JMP/CALL.
// Also used by the skip logic (CPSE/SBRC) to size the skipped instruction.
module two_word_detect
    import avr_core_pkg::*;
(
    input  logic [15:0] word,
    output logic        two_word
);

    // Classify the word against the two-word opcode patterns
    always_comb begin
        two_word = is_two_word(word);
    end

endmodule

// File: rtl/instruction_sequencer.sv
// Fetch/execute controller ahead of the instruction decoder.
// Fetches program words over a req/ack handshake, owns the program counter
// and instruction register, gathers the second word of two-word instructions
// and issues a one-cycle GPR write strobe when an instruction retires.
// Optional build macro RETIRE_COUNTER_EN adds a retired-instruction counter
// (retired_count) with a synchronous clear input (retired_clear).
module instruction_sequencer
    import avr_core_pkg::*;
#(
    parameter int                    PC_WIDTH     = SEQ_PC_WIDTH,
    parameter logic [PC_WIDTH-1:0]   RESET_VECTOR = {PC_WIDTH{1'b0}}
)
(
    input  logic                clk,
    input  logic                reset_n,
    output logic [PC_WIDTH-1:0] pmem_addr,
    output logic                pmem_req,
    input  logic                pmem_ack,
    input  logic [15:0]         pmem_data,
    input  logic                halt_in,
    input  logic                stall_in,
    input  logic                jump_valid,
    input  logic [PC_WIDTH-1:0] jump_target,
    output logic [15:0]         instruction_out,
    output logic [15:0]         ext_word_out,
    output logic                ext_valid_out,
    input  logic                decoder_gpr_write_in,
    output logic                gpr_write_strobe,
    output logic [PC_WIDTH-1:0] pc_out,
`ifdef RETIRE_COUNTER_EN
    input  logic                retired_clear,
    output logic [31:0]         retired_count,
`endif
    output logic                busy
);

    localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    logic [2:0]          state_r;
    logic [PC_WIDTH-1:0] pc_r;
    logic                two_word_s;
    logic                exec_exit_s;

    two_word_detect u_two_word_detect (
        .word     (pmem_data),
        .two_word (two_word_s)
    );

    // An instruction retires on the first unstalled EXECUTE cycle
    always_comb begin
        exec_exit_s = (state_r == SEQ_EXECUTE) && !stall_in;
    end

    // Sequencer FSM with all datapath registers and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r          <= SEQ_FETCH;
            pc_r             <= RESET_VECTOR;
            pc_out           <= RESET_VECTOR;
            pmem_addr        <= RESET_VECTOR;
            pmem_req         <= 1'b0;
            instruction_out  <= OPC_NOP;
            ext_word_out     <= 16'h0000;
            ext_valid_out    <= 1'b0;
            gpr_write_strobe <= 1'b0;
            busy             <= 1'b1;
        end else begin
            gpr_write_strobe <= 1'b0;
            case (state_r)
                SEQ_FETCH: begin
                    if (halt_in) begin
                        state_r <= SEQ_HALTED;
                        busy    <= 1'b0;
                    end else begin
                        pmem_addr <= pc_r;
                        pmem_req  <= 1'b1;
                        state_r   <= SEQ_WAIT;
                    end
                end
                SEQ_WAIT: begin
                    // Address and request stay stable until the ack arrives
                    if (pmem_ack) begin
                        instruction_out <= pmem_data;
                        pc_out          <= pc_r;
                        pc_r            <= pc_r + PC_ONE;
                        ext_valid_out   <= 1'b0;
                        pmem_req        <= 1'b0;
                        state_r         <= two_word_s ? SEQ_FETCH_EXT : SEQ_EXECUTE;
                    end else begin
                        state_r <= SEQ_WAIT;
                    end
                end
                SEQ_FETCH_EXT: begin
                    // halt_in is not looked at: a two-word instruction is never split
                    pmem_addr <= pc_r;
                    pmem_req  <= 1'b1;
                    state_r   <= SEQ_WAIT_EXT;
                end
                SEQ_WAIT_EXT: begin
                    if (pmem_ack) begin
                        ext_word_out  <= pmem_data;
                        ext_valid_out <= 1'b1;
                        pc_r          <= pc_r + PC_ONE;
                        pmem_req      <= 1'b0;
                        state_r       <= SEQ_EXECUTE;
                    end else begin
                        state_r <= SEQ_WAIT_EXT;
                    end
                end
                SEQ_EXECUTE: begin
                    if (exec_exit_s) begin
                        gpr_write_strobe <= decoder_gpr_write_in;
                        if (jump_valid) begin
                            pc_r <= jump_target;
                        end else begin
                            pc_r <= pc_r;
                        end
                        state_r <= SEQ_FETCH;
                    end else begin
                        state_r <= SEQ_EXECUTE;
                    end
                end
                SEQ_HALTED: begin
                    if (halt_in) begin
                        state_r <= SEQ_HALTED;
                    end else begin
                        state_r <= SEQ_FETCH;
                        busy    <= 1'b1;
                    end
                end
                default: begin
                    state_r  <= SEQ_FETCH;
                    pmem_req <= 1'b0;
                    busy     <= 1'b1;
                end
            endcase
        end
    end

`ifdef RETIRE_COUNTER_EN
    // Count retired instructions; a clear in the same cycle as a retire wins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            retired_count <= 32'd0;
        end else if (retired_clear) begin
            retired_count <= 32'd0;
        end else if (exec_exit_s) begin
            retired_count <= retired_count + 32'd1;
        end else begin
            retired_count <= retired_count;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench for instruction_sequencer: directed steps followed by a
// randomized run, checked against an instruction-level program model.
module tb_instruction_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [13:0] pmem_addr;
    logic        pmem_req;
    logic        pmem_ack;
    logic [15:0] pmem_data;
    logic        halt_in;
    logic        stall_in;
    logic        jump_valid;
    logic [13:0] jump_target;
    logic [15:0] instruction_out;
    logic [15:0] ext_word_out;
    logic        ext_valid_out;
    logic        decoder_gpr_write_in;
    logic        gpr_write_strobe;
    logic [13:0] pc_out;
    logic        busy;
`ifdef RETIRE_COUNTER_EN
    logic        retired_clear;
    logic [31:0] retired_count;
`endif

    instruction_sequencer dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .pmem_addr            (pmem_addr),
        .pmem_req             (pmem_req),
        .pmem_ack             (pmem_ack),
        .pmem_data            (pmem_data),
        .halt_in              (halt_in),
        .stall_in             (stall_in),
        .jump_valid           (jump_valid),
        .jump_target          (jump_target),
        .instruction_out      (instruction_out),
        .ext_word_out         (ext_word_out),
        .ext_valid_out        (ext_valid_out),
        .decoder_gpr_write_in (decoder_gpr_write_in),
        .gpr_write_strobe     (gpr_write_strobe),
        .pc_out               (pc_out),
`ifdef RETIRE_COUNTER_EN
        .retired_clear        (retired_clear),
        .retired_count        (retired_count),
`endif
        .busy                 (busy)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:16383];
    int          checks = 0;
    int          errors = 0;

    // program model state
    logic [13:0] model_pc;
    int          fetch_idx;
    int          n_retired;
    bit          model_en;
    // memory responder state
    bit          stray_en;
    bit          rand_lat;
    int          lat_cnt;
    int          cur_lat;
    // per-cycle event flags
    bit          req_rose;
    bit          strobe_seen;

    // AVR two-word opcodes: LDS/STS 1001 00xd dddd 0000, JMP/CALL 1001 010k kkkk 11xk
    function automatic bit two_word_ref(input logic [15:0] w);
        return (w[15:10] == 6'b100100 && w[3:0] == 4'b0000) ||
               (w[15:9] == 7'b1001010 && w[3:2] == 2'b11);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: memory responder plus program-model monitor
    task automatic tick();
        logic        p_stall;
        logic        p_jv;
        logic        p_req;
        logic [13:0] p_tgt;
        logic [13:0] nxt;
        logic [15:0] w;
        bit          two;
        p_stall = stall_in;
        p_jv    = jump_valid;
        p_tgt   = jump_target;
        p_req   = pmem_req;
        @(posedge clk);
        #1;
        req_rose    = pmem_req && !p_req;
        strobe_seen = gpr_write_strobe;
        pmem_ack = 1'b0;
        if (pmem_req) begin
            if (lat_cnt >= cur_lat) begin
                pmem_ack  = 1'b1;
                pmem_data = mem[pmem_addr];
                lat_cnt   = 0;
                cur_lat   = rand_lat ? int'($urandom_range(0, 3)) : 0;
            end else begin
                lat_cnt++;
            end
        end else begin
            lat_cnt = 0;
            if (stray_en && $urandom_range(0, 3) == 0) begin
                pmem_ack  = 1'b1;
                pmem_data = 16'($urandom);
            end
        end
        if (model_en && gpr_write_strobe) begin
            w   = mem[model_pc];
            two = two_word_ref(w);
            nxt = model_pc + 14'd1;
            check("retire_while_stalled", 32'(p_stall), 32'd0);
            check("instruction_out", 32'(instruction_out), 32'(w));
            check("pc_out", 32'(pc_out), 32'(model_pc));
            check("ext_valid_out", 32'(ext_valid_out), 32'(two));
            if (two) check("ext_word_out", 32'(ext_word_out), 32'(mem[nxt]));
            check("fetches_per_instr", fetch_idx, two ? 32'd2 : 32'd1);
            model_pc  = p_jv ? p_tgt : (two ? model_pc + 14'd2 : nxt);
            fetch_idx = 0;
            n_retired++;
        end
        if (model_en && req_rose) begin
            nxt = model_pc + 14'd1;
            if (fetch_idx == 0) begin
                check("fetch_addr", 32'(pmem_addr), 32'(model_pc));
            end else begin
                check("ext_fetch_needed", 32'(two_word_ref(mem[model_pc]) && fetch_idx == 1), 32'd1);
                check("ext_fetch_addr", 32'(pmem_addr), 32'(nxt));
            end
            fetch_idx++;
        end
    endtask

    task automatic wait_strobe(input string tag);
        int n = 0;
        tick();
        while (!strobe_seen && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_seen"}, 32'(strobe_seen), 32'd1);
    endtask

    task automatic wait_req(input string tag, input logic [13:0] expaddr, input bit chk);
        int n = 0;
        tick();
        while (!req_rose && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_req"}, 32'(req_rose), 32'd1);
        if (chk) check(tag, 32'(pmem_addr), 32'(expaddr));
    endtask

    initial begin
        int strobes;
        int rises;
        reset_n = 1'b0; halt_in = 1'b0; stall_in = 1'b0; jump_valid = 1'b0;
        jump_target = 14'd0; decoder_gpr_write_in = 1'b1; pmem_ack = 1'b0; pmem_data = 16'h0000;
`ifdef RETIRE_COUNTER_EN
        retired_clear = 1'b0;
`endif
        model_en = 1'b1; model_pc = 14'd0; fetch_idx = 0; n_retired = 0;
        stray_en = 1'b0; rand_lat = 1'b0; lat_cnt = 0; cur_lat = 0;
        for (int i = 0; i < 16384; i++) begin
            int r;
            r = int'($urandom_range(0, 3));
            if (r == 0)      mem[i] = 16'h9000 | (16'($urandom) & 16'h03F0);
            else if (r == 1) mem[i] = 16'h940C | (16'($urandom) & 16'h01F3);
            else             mem[i] = 16'($urandom);
        end
        mem[0] = 16'hE5AF; mem[1] = 16'h0000; mem[2] = 16'h0000; mem[3] = 16'h0000;
        mem[4] = 16'h9100; mem[5] = 16'h0060; mem[6] = 16'h0000; mem[7] = 16'h0000;
        mem[14'h0100] = 16'h0000; mem[14'h3FFF] = 16'h0000;

        // reset values
        repeat (3) @(negedge clk);
        check("rst_req", 32'(pmem_req), 32'd0);
        check("rst_addr", 32'(pmem_addr), 32'd0);
        check("rst_instr", 32'(instruction_out), 32'h0000);
        check("rst_ext_word", 32'(ext_word_out), 32'd0);
        check("rst_ext_valid", 32'(ext_valid_out), 32'd0);
        check("rst_strobe", 32'(gpr_write_strobe), 32'd0);
        check("rst_pc_out", 32'(pc_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;

        // LDI fetched with one-cycle ack latency
        tick();
        check("ldi_req", 32'(pmem_req), 32'd1);
        check("ldi_addr", 32'(pmem_addr), 32'd0);
        tick();
        check("ldi_instr_c2", 32'(instruction_out), 32'hE5AF);
        check("ldi_no_strobe_c2", 32'(gpr_write_strobe), 32'd0);
        check("ldi_req_drop", 32'(pmem_req), 32'd0);
        tick();
        check("ldi_strobe_c3", 32'(gpr_write_strobe), 32'd1);
        check("ldi_pc_out", 32'(pc_out), 32'd0);
        tick();
        check("ldi_strobe_once", 32'(gpr_write_strobe), 32'd0);
        check("ldi_next_req", 32'(pmem_req), 32'd1);
        check("ldi_next_addr", 32'(pmem_addr), 32'd1);

        // LDS at address 4 with its 0x0060 operand
        repeat (4) wait_strobe("lds_strobe");
        check("lds_instr", 32'(instruction_out), 32'h9100);
        check("lds_ext_word", 32'(ext_word_out), 32'h0060);
        check("lds_ext_valid", 32'(ext_valid_out), 32'd1);
        check("lds_pc_out", 32'(pc_out), 32'd4);
        wait_req("lds_next_fetch", 14'd6, 1'b1);

        // three stalled EXECUTE cycles, then a single strobe
        stall_in = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_no_strobe", 32'(gpr_write_strobe), 32'd0);
            check("stall_no_req", 32'(pmem_req), 32'd0);
        end
        stall_in = 1'b0;
        tick();
        check("stall_release_strobe", 32'(gpr_write_strobe), 32'd1);

        // jump pulse in WAIT is ignored; jump at EXECUTE exit is taken
        wait_req("jmp_fetch7", 14'd7, 1'b1);
        jump_valid = 1'b1; jump_target = 14'h0200;
        tick();
        jump_target = 14'h0100;
        tick();
        jump_valid = 1'b0;
        check("jmp_exit_strobe", 32'(gpr_write_strobe), 32'd1);
        wait_req("jmp_target_fetch", 14'h0100, 1'b1);

        // wrap from 0x3FFF to 0x0000
        tick();
        jump_valid = 1'b1; jump_target = 14'h3FFF;
        tick();
        jump_valid = 1'b0;
        wait_req("wrap_fetch_3fff", 14'h3FFF, 1'b1);
        wait_req("wrap_fetch_0", 14'h0000, 1'b1);

        // halt raised during WAIT: instruction completes, then HALTED
        halt_in = 1'b1;
        tick();
        check("halt_fetch_completes", 32'(instruction_out), 32'hE5AF);
        tick();
        check("halt_executes", 32'(gpr_write_strobe), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("halted_busy", 32'(busy), 32'd0);
            check("halted_no_req", 32'(pmem_req), 32'd0);
            check("halted_instr_held", 32'(instruction_out), 32'hE5AF);
        end
        halt_in = 1'b0;
        tick();
        check("unhalt_busy", 32'(busy), 32'd1);
        wait_req("unhalt_fetch", 14'd1, 1'b1);

        // randomized run against the program model
        mem[14'h3FFF] = 16'h9000;
        stray_en = 1'b1; rand_lat = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            int r;
            stall_in   = ($urandom_range(0, 3) == 0);
            jump_valid = ($urandom_range(0, 4) == 0);
            halt_in    = ($urandom_range(0, 19) == 0);
            r = int'($urandom_range(0, 7));
            if (r == 0)      jump_target = 14'h3FFF;
            else if (r == 1) jump_target = 14'h3FFE;
            else             jump_target = 14'($urandom);
            tick();
        end
        stall_in = 1'b0; jump_valid = 1'b0; halt_in = 1'b0;
        stray_en = 1'b0; rand_lat = 1'b0;
        check("random_progress", 32'(n_retired > 200), 32'd1);

        // decoder not writing: instructions retire with no strobe
        model_en = 1'b0;
        decoder_gpr_write_in = 1'b0;
        strobes = 0; rises = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (strobe_seen) strobes++;
            if (req_rose) rises++;
        end
        check("no_decoder_write_no_strobe", strobes, 32'd0);
        check("no_decoder_write_progress", 32'(rises >= 3), 32'd1);

        // reset in the middle of a fetch, with a late ack
        wait_req("midreset_fetch", 14'd0, 1'b0);
        #1;
        reset_n = 1'b0;
        #1;
        check("midreset_req_drop", 32'(pmem_req), 32'd0);
        check("midreset_addr", 32'(pmem_addr), 32'd0);
        check("midreset_pc_out", 32'(pc_out), 32'd0);
        check("midreset_instr", 32'(instruction_out), 32'h0000);
        pmem_ack = 1'b1; pmem_data = 16'hFFFF;
        lat_cnt = 0; cur_lat = 0;
        @(negedge clk);
        reset_n = 1'b1;
        model_pc = 14'd0; fetch_idx = 0; model_en = 1'b1;
        decoder_gpr_write_in = 1'b1;
        wait_req("postreset_fetch", 14'd0, 1'b1);
        wait_strobe("postreset_strobe");
        check("postreset_instr", 32'(instruction_out), 32'hE5AF);

`ifdef RETIRE_COUNTER_EN
        check("retired_after_one", retired_count, 32'd1);
        repeat (9) wait_strobe("retire_strobe");
        check("retired_ten", retired_count, 32'd10);
        retired_clear = 1'b1;
        wait_strobe("retire_clear_strobe");
        retired_clear = 1'b0;
        check("retired_clear_wins", retired_count, 32'd0);
        wait_strobe("retire_after_clear");
        check("retired_after_clear", retired_count, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
